// File: rtl/cs_arbiter_pkg.sv
// Shared types and constants for the chip-select round-robin arbiter.
package cs_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // '138-style enable triplet {E3, nE2, nE1}
  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;

  function automatic logic [N_REQ-1:0] dec_low(input logic [IDX_W-1:0] idx);
    return ~(N_REQ'(1) << idx);
  endfunction

endpackage

// File: rtl/cs_arbiter_if.sv
// Request/grant bundle between requesters and the chip-select arbiter.
interface cs_arbiter_if;
  import cs_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] a;
  logic [2:0]       e;
  logic [N_REQ-1:0] n_y;
  logic             busy;
  logic             to;

  modport slave  (input  req, output a, e, n_y, busy, to);
  modport master (output req, input  a, e, n_y, busy, to);

endinterface

// File: rtl/cs_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after last_holder.
module cs_arbiter_rr_pick
  import cs_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_holder,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest offset so the nearest active request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = last_holder + IDX_W'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cs_arbiter.sv
// Round-robin chip-select arbiter with break-before-make gap.
// Optional hold timeout enabled by defining CS_ARBITER_TIMEOUT_EN.
module cs_arbiter
  import cs_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 1
) (
  input  logic         clk,
  input  logic         rst,
  cs_arbiter_if.slave  bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] a_q, a_d;
  logic [2:0]       e_q, e_d;
  logic [N_REQ-1:0] ny_q, ny_d;
  logic             busy_q, busy_d;
  logic [3:0]       gap_q, gap_d;
  logic             arb, rel;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
`ifdef CS_ARBITER_TIMEOUT_EN
  logic [15:0]      hold_q, hold_d;
  logic             to_q, to_d;
`endif

  cs_arbiter_rr_pick u_pick (
    .req         (bus.req),
    .last_holder (last_q),
    .valid       (pick_valid),
    .idx         (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    e_d     = e_q;
    ny_d    = ny_q;
    busy_d  = busy_q;
    gap_d   = gap_q;
    arb     = 1'b0;
    rel     = 1'b0;
`ifdef CS_ARBITER_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE:  arb = 1'b1;
      GRANT: begin
        if (!bus.req[a_q]) begin
          rel = 1'b1;
`ifdef CS_ARBITER_TIMEOUT_EN
        end else if (hold_q == 16'(TIMEOUT_CYCLES - 1)) begin
          rel  = 1'b1;
          to_d = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
`endif
        end
      end
      // Last gap cycle arbitrates directly so spacing stays GAP_CYCLES+1.
      GAP: begin
        if (gap_q == 4'd0) arb = 1'b1;
        else               gap_d = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      state_d = GAP;
      last_d  = a_q;
      a_d     = '0;
      e_d     = EN_OFF;
      ny_d    = '1;
      busy_d  = 1'b1;
      gap_d   = 4'(GAP_CYCLES - 1);
    end

    if (arb) begin
      if (pick_valid) begin
        state_d = GRANT;
        a_d     = pick_idx;
        e_d     = EN_ON;
        ny_d    = dec_low(pick_idx);
        busy_d  = 1'b1;
`ifdef CS_ARBITER_TIMEOUT_EN
        hold_d  = '0;
`endif
      end else begin
        state_d = IDLE;
        a_d     = '0;
        e_d     = EN_OFF;
        ny_d    = '1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      a_q     <= '0;
      e_q     <= EN_OFF;
      ny_q    <= '1;
      busy_q  <= 1'b0;
      gap_q   <= '0;
`ifdef CS_ARBITER_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      e_q     <= e_d;
      ny_q    <= ny_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
`ifdef CS_ARBITER_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.a    = a_q;
  assign bus.e    = e_q;
  assign bus.n_y  = ny_q;
  assign bus.busy = busy_q;
`ifdef CS_ARBITER_TIMEOUT_EN
  assign bus.to   = to_q;
`else
  assign bus.to   = 1'b0;
`endif

endmodule

// File: doc/cs_arbiter.md
CS_ARBITER -- requirements
Module: cs_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the maximum number of GRANT cycles for one holder, range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 1: the number of dead cycles between grants with all selects inactive, range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ  input  8  per-requester request, active-high, held by the requester for as long as it wants the resource.
REQ-006 A  output  3  binary index of the current holder; 3'b000 when no grant is active.
REQ-007 E  output  3  '138-style enables {E3,nE2,nE1}; 3'b100 when a grant is active, else 3'b011.
REQ-008 nY  output  8  decoded grant, active-low one-hot; 8'hFF when no grant is active.
REQ-009 BUSY  output  1  high in the GRANT and GAP states.
REQ-010 TO  output  1  one-cycle pulse on a forced release; tied low when the timeout feature is compiled out.

Function
REQ-011 The state machine SHALL have three states: IDLE, GRANT and GAP.
REQ-012 IDLE to GRANT: when any REQ bit is high, the arbiter picks a winner by round-robin and registers the grant; the grant is visible on A, E and nY one cycle after REQ is sampled.
REQ-013 Round-robin search order starts at index (last_holder+1) mod 8 and wraps 7 to 0; after reset, last_holder is 7, so index 0 has first priority.
REQ-014 GRANT to GAP: when REQ[A] is sampled low, outputs go inactive in the next cycle and last_holder takes the value A.
REQ-015 In GAP, nY is 8'hFF for exactly GAP_CYCLES cycles (break-before-make); GAP then returns to IDLE, which re-arbitrates in the same cycle, so the minimum spacing from release to the next grant is GAP_CYCLES+1 cycles.
REQ-016 nY SHALL equal ~(8'b1 << A) when E is 3'b100, and 8'hFF otherwise; all outputs are registered and glitch-free.
REQ-017 Changes on non-holder REQ bits during GRANT SHALL have no effect; there is no preemption.
REQ-018 When the holder releases while others are requesting, the winner is the next requester after the holder in round-robin order.
REQ-019 A REQ pulse shorter than one cycle seen in IDLE still yields a grant, which is then released on the following sample.

Reset
REQ-020 While RST is high: state is IDLE, A is 0, E is 3'b011, nY is 8'hFF, BUSY is 0, TO is 0, last_holder is 7, and counters are 0.
REQ-021 Reset asserted mid-GRANT or mid-GAP SHALL drop the grant immediately, without waiting for a clock edge.
REQ-022 After RST is deasserted, the first arbitration happens on the first rising edge.

Configuration
REQ-023 Macro CS_ARBITER_TIMEOUT_EN, when defined, adds a 16-bit hold counter that clears on entry to GRANT and increments each GRANT cycle.
REQ-024 When the count reaches TIMEOUT_CYCLES, the arbiter SHALL force GRANT to GAP, pulse TO for one cycle, and update last_holder as in a normal release.
REQ-025 When the macro is undefined, there is no counter, TO is constant 0, and a grant is held indefinitely.

Structure
REQ-026 Shared package cs_arbiter_pkg SHALL hold: the state enum (IDLE, GRANT, GAP), N_REQ=8, IDX_W=3, and the enable constants EN_ON=3'b100 and EN_OFF=3'b011.
REQ-027 Sub-module cs_arbiter_rr_pick SHALL be purely combinational: input REQ[7:0] and last_holder[2:0]; outputs valid and idx[2:0].
REQ-028 The FSM, counters and output registers SHALL live in cs_arbiter.

Verification
REQ-029 Reset, then REQ=8'h01 -> next cycle A=0, E=3'b100, nY=8'hFE, BUSY=1.
REQ-030 REQ=8'h81 held with last_holder=7 -> grant to 0 (nY=8'hFE); drop REQ[0] -> nY=8'hFF for 1 cycle, then nY=8'h7F, A=7.
REQ-031 All REQ=8'hFF, each holder releasing after 3 cycles -> grant order 0,1,...,7,0 with one 8'hFF gap cycle between grants.
REQ-032 RST pulsed mid-GRANT with A=5 -> nY=8'hFF and BUSY=0 asynchronously; after release, REQ=8'h20 is granted again.
REQ-033 With CS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, REQ[2] held -> 4 grant cycles, then TO=1 for 1 cycle, a gap, and a re-grant to 2 if it is the only requester.
REQ-034 Without the macro, REQ[2] held for 1000 cycles -> nY stays 8'hFB and TO stays 0.
